// File: rtl/xbar_slave_read_port.sv
// Master-side read front-end of the crossbar: buffers and decodes outer-master AR
// requests, and arbitrates/buffers R bursts returned by the slave interfaces.
module xbar_slave_read_port #(
  parameter int unsigned ID_WIDTH           = 4,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned LEN_WIDTH          = 4,
  parameter int unsigned SIZE_WIDTH         = 3,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned pending_depth      = 8,
  parameter int unsigned slaves             = 2,
  parameter int unsigned masters            = 2,
  parameter int unsigned i_am_master_number = 0,
  localparam int unsigned SW = $clog2(slaves),
  localparam int unsigned MW = (masters > 1) ? $clog2(masters) : 1
) (
  input  logic                                ACLK,
  input  logic                                ARESETn,
  input  logic [ID_WIDTH-1:0]                 ARID_M,
  input  logic [ADDR_WIDTH-1:0]               ARADDR_M,
  input  logic [LEN_WIDTH-1:0]                ARLEN_M,
  input  logic [SIZE_WIDTH-1:0]               ARSIZE_M,
  input  logic [1:0]                          ARBURST_M,
  input  logic                                ARVALID_M,
  output logic                                ARREADY_M,
  output logic [ID_WIDTH-1:0]                 RID_M,
  output logic [DATA_WIDTH-1:0]               RDATA_M,
  output logic [1:0]                          RRESP_M,
  output logic                                RLAST_M,
  output logic                                RVALID_M,
  input  logic                                RREADY_M,
  output logic [ID_WIDTH-1:0]                 ARID,
  output logic [ADDR_WIDTH-1:0]               ARADDR,
  output logic [LEN_WIDTH-1:0]                ARLEN,
  output logic [SIZE_WIDTH-1:0]               ARSIZE,
  output logic [1:0]                          ARBURST,
  output logic                                master_read_addr_fifo_empty,
  output logic [SW-1:0]                       read_addr_forward_dest_slave,
  input  logic [slaves-1:0]                   slave_read_addr_fifo_full,
  input  logic [slaves-1:0][MW-1:0]           grant_read_addr_forward_master,
  input  logic [slaves-1:0][ID_WIDTH-1:0]     RID_X,
  input  logic [slaves-1:0][DATA_WIDTH-1:0]   RDATA_X,
  input  logic [slaves-1:0][1:0]              RRESP_X,
  input  logic [slaves-1:0]                   RLAST_X,
  input  logic [slaves-1:0]                   slave_read_data_fifo_empty,
  input  logic [slaves-1:0][MW-1:0]           read_data_return_dest_master,
  output logic                                master_read_data_fifo_full,
  output logic [SW-1:0]                       master_grant_read_data_slave_number
);

  localparam int unsigned AW = $clog2(pending_depth);
  localparam logic [MW-1:0] MY_ID = MW'(i_am_master_number);
  localparam logic [AW:0]   DEPTH = (AW+1)'(pending_depth);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [SIZE_WIDTH-1:0] size;
    logic [1:0]            burst;
    logic [SW-1:0]         dest;
  } ar_entry_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_entry_t;

  typedef enum logic {IDLE, LOCK} arb_state_t;

  // ---------------- AR FIFO ----------------
  ar_entry_t       ar_mem [pending_depth];
  logic [AW-1:0]   ar_wr_q, ar_rd_q;
  logic [AW:0]     ar_cnt_q;
  logic            ar_full, ar_empty, ar_push, ar_pop;
  logic [SW-1:0]   push_dest;
  ar_entry_t       ar_front;

  assign ar_full  = (ar_cnt_q == DEPTH);
  assign ar_empty = (ar_cnt_q == '0);
  assign ar_front = ar_mem[ar_rd_q];

  always_comb begin
    push_dest = ARADDR_M[ADDR_WIDTH-1 -: SW];
    if (32'(push_dest) >= slaves) push_dest = SW'(slaves - 1);
  end

  assign ARREADY_M = ARESETn & ~ar_full;
  assign ar_push   = ARVALID_M & ARREADY_M;
  // Mirrors the slave interface's push condition so both sides agree on the handoff.
  assign ar_pop    = ~ar_empty
                   & (grant_read_addr_forward_master[ar_front.dest] == MY_ID)
                   & ~slave_read_addr_fifo_full[ar_front.dest];

  always_ff @(posedge ACLK) begin
    if (ar_push) ar_mem[ar_wr_q] <= '{id: ARID_M, addr: ARADDR_M, len: ARLEN_M,
                                      size: ARSIZE_M, burst: ARBURST_M, dest: push_dest};
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ar_wr_q  <= '0;
      ar_rd_q  <= '0;
      ar_cnt_q <= '0;
    end else begin
      if (ar_push) ar_wr_q <= ar_wr_q + AW'(1);
      if (ar_pop)  ar_rd_q <= ar_rd_q + AW'(1);
      case ({ar_push, ar_pop})
        2'b10:   ar_cnt_q <= ar_cnt_q + (AW+1)'(1);
        2'b01:   ar_cnt_q <= ar_cnt_q - (AW+1)'(1);
        default: ar_cnt_q <= ar_cnt_q;
      endcase
    end
  end

  assign ARID    = ar_front.id;
  assign ARADDR  = ar_front.addr;
  assign ARLEN   = ar_front.len;
  assign ARSIZE  = ar_front.size;
  assign ARBURST = ar_front.burst;
  assign read_addr_forward_dest_slave = ar_front.dest;
  assign master_read_addr_fifo_empty  = ar_empty;

  // ---------------- R arbiter ----------------
  arb_state_t      state_q;
  logic [SW-1:0]   grant_q, rr_ptr_q, pick_idx;
  logic            grant_valid_q, pick_found;
  logic [slaves-1:0] req;
  logic            r_full, r_empty, r_push, r_pop;

  always_comb begin
    for (int unsigned s = 0; s < slaves; s++)
      req[s] = ~slave_read_data_fifo_empty[s] & (read_data_return_dest_master[s] == MY_ID);
  end

  always_comb begin
    int unsigned k;
    k          = 0;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < slaves; i++) begin
      k = (32'(rr_ptr_q) + i) % slaves;
      if (!pick_found && req[SW'(k)]) begin
        pick_found = 1'b1;
        pick_idx   = SW'(k);
      end
    end
  end

  assign r_push = (state_q == LOCK) & req[grant_q] & ~r_full;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (pick_found) begin
          state_q       <= LOCK;
          grant_q       <= pick_idx;
          grant_valid_q <= 1'b1;
        end
        LOCK: if (r_push && RLAST_X[grant_q]) begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
          rr_ptr_q      <= SW'((32'(grant_q) + 1) % slaves);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Force "full" while unlocked so no slave pops against a stale grant number.
  assign master_read_data_fifo_full          = r_full | ~grant_valid_q;
  assign master_grant_read_data_slave_number = grant_q;

  // ---------------- R FIFO ----------------
  r_entry_t        r_mem [pending_depth];
  logic [AW-1:0]   r_wr_q, r_rd_q;
  logic [AW:0]     r_cnt_q;
  r_entry_t        r_front;

  assign r_full  = (r_cnt_q == DEPTH);
  assign r_empty = (r_cnt_q == '0);
  assign r_pop   = ~r_empty & RREADY_M;
  assign r_front = r_mem[r_rd_q];

  always_ff @(posedge ACLK) begin
    if (r_push) r_mem[r_wr_q] <= '{id: RID_X[grant_q], data: RDATA_X[grant_q],
                                   resp: RRESP_X[grant_q], last: RLAST_X[grant_q]};
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wr_q  <= '0;
      r_rd_q  <= '0;
      r_cnt_q <= '0;
    end else begin
      if (r_push) r_wr_q <= r_wr_q + AW'(1);
      if (r_pop)  r_rd_q <= r_rd_q + AW'(1);
      case ({r_push, r_pop})
        2'b10:   r_cnt_q <= r_cnt_q + (AW+1)'(1);
        2'b01:   r_cnt_q <= r_cnt_q - (AW+1)'(1);
        default: r_cnt_q <= r_cnt_q;
      endcase
    end
  end

  assign RVALID_M = ~r_empty;
  assign RID_M    = r_front.id;
  assign RDATA_M  = r_front.data;
  assign RRESP_M  = r_front.resp;
  assign RLAST_M  = r_front.last;

endmodule

// File: tb/tb_xbar_slave_read_port.sv
// Directed bench for xbar_slave_read_port: AR decode/backpressure, R arbitration,
// foreign beats, R FIFO full and asynchronous reset.
module tb_xbar_slave_read_port;
  localparam int unsigned S = 2;

  logic              clk = 1'b0;
  logic              ARESETn;
  logic [3:0]        ARID_M;
  logic [31:0]       ARADDR_M;
  logic [3:0]        ARLEN_M;
  logic [2:0]        ARSIZE_M;
  logic [1:0]        ARBURST_M;
  logic              ARVALID_M, ARREADY_M;
  logic [3:0]        RID_M;
  logic [31:0]       RDATA_M;
  logic [1:0]        RRESP_M;
  logic              RLAST_M, RVALID_M, RREADY_M;
  logic [3:0]        ARID;
  logic [31:0]       ARADDR;
  logic [3:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              mar_empty;
  logic              ar_dest;
  logic [S-1:0]      sa_full;
  logic [S-1:0][0:0] sa_grant;
  logic [S-1:0][3:0] RID_X;
  logic [S-1:0][31:0] RDATA_X;
  logic [S-1:0][1:0] RRESP_X;
  logic [S-1:0]      RLAST_X;
  logic [S-1:0]      sr_empty;
  logic [S-1:0][0:0] sr_dm;
  logic              mrd_full;
  logic              rgrant;

  int errors = 0;
  int checks = 0;
  int rem [S];
  int beat [S];
  logic dm [S];
  logic [31:0] cap_data [16];
  logic        cap_last [16];
  int ncap = 0;

  xbar_slave_read_port #(.slaves(2), .masters(2), .i_am_master_number(0), .pending_depth(8)) dut (
    .ACLK(clk), .ARESETn(ARESETn),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .master_read_addr_fifo_empty(mar_empty), .read_addr_forward_dest_slave(ar_dest),
    .slave_read_addr_fifo_full(sa_full), .grant_read_addr_forward_master(sa_grant),
    .RID_X(RID_X), .RDATA_X(RDATA_X), .RRESP_X(RRESP_X), .RLAST_X(RLAST_X),
    .slave_read_data_fifo_empty(sr_empty), .read_data_return_dest_master(sr_dm),
    .master_read_data_fifo_full(mrd_full), .master_grant_read_data_slave_number(rgrant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave R FIFO model: slave s holds rem[s] beats, data A000_0000 | s<<8 | beat index.
  task automatic drive_slaves();
    for (int s = 0; s < S; s++) begin
      sr_empty[s] = (rem[s] == 0);
      RDATA_X[s]  = 32'hA000_0000 | (32'(s) << 8) | 32'(beat[s]);
      RLAST_X[s]  = (rem[s] == 1);
      RID_X[s]    = 4'(s + 3);
      RRESP_X[s]  = 2'b00;
      sr_dm[s]    = dm[s];
    end
  endtask

  task automatic tick();
    logic [S-1:0] pop;
    #1;
    for (int s = 0; s < S; s++)
      pop[s] = !mrd_full && (32'(rgrant) == 32'(s)) && (rem[s] != 0);
    if (RVALID_M && RREADY_M && ncap < 16) begin
      cap_data[ncap] = RDATA_M;
      cap_last[ncap] = RLAST_M;
      ncap++;
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < S; s++)
      if (pop[s]) begin rem[s]--; beat[s]++; end
    drive_slaves();
    #1;
  endtask

  initial begin
    ARESETn = 1'b0;
    ARID_M = '0; ARADDR_M = '0; ARLEN_M = '0; ARSIZE_M = '0; ARBURST_M = '0;
    ARVALID_M = 1'b0; RREADY_M = 1'b0;
    sa_full = 2'b11; sa_grant = '0;
    for (int s = 0; s < S; s++) begin rem[s] = 0; beat[s] = 0; dm[s] = 1'b0; end
    drive_slaves();
    #3;
    chk("rst_arready", 64'(ARREADY_M), 64'd0);
    chk("rst_rvalid", 64'(RVALID_M), 64'd0);
    chk("rst_ar_empty", 64'(mar_empty), 64'd1);
    chk("rst_r_full", 64'(mrd_full), 64'd1);
    chk("rst_rgrant", 64'(rgrant), 64'd0);
    tick(); tick();
    ARESETn = 1'b1;
    #1;
    chk("post_rst_arready", 64'(ARREADY_M), 64'd1);

    // Single read to slave 1 (MSB of address)
    sa_full = 2'b01;
    ARVALID_M = 1'b1; ARID_M = 4'd5; ARADDR_M = 32'h8000_0000;
    ARLEN_M = 4'd3; ARSIZE_M = 3'd2; ARBURST_M = 2'd1;
    tick();
    ARVALID_M = 1'b0;
    chk("single_not_empty", 64'(mar_empty), 64'd0);
    chk("single_dest", 64'(ar_dest), 64'd1);
    chk("single_arid", 64'(ARID), 64'd5);
    chk("single_araddr", 64'(ARADDR), 64'h8000_0000);
    chk("single_arlen", 64'(ARLEN), 64'd3);
    tick();
    chk("single_popped", 64'(mar_empty), 64'd1);

    // Backpressure: slave 0 AR FIFO full, fill 8 entries
    for (int i = 0; i < 8; i++) begin
      ARVALID_M = 1'b1; ARID_M = 4'(i); ARADDR_M = 32'(i) << 4;
      tick();
    end
    ARVALID_M = 1'b0;
    chk("bp_arready_full", 64'(ARREADY_M), 64'd0);
    chk("bp_front_id", 64'(ARID), 64'd0);
    chk("bp_dest0", 64'(ar_dest), 64'd0);
    sa_full = 2'b00;
    tick();
    chk("bp_arready_after_pop", 64'(ARREADY_M), 64'd1);
    for (int k = 1; k < 8; k++) begin
      chk("bp_pop_order", 64'(ARID), 64'(k));
      tick();
    end
    chk("bp_drained", 64'(mar_empty), 64'd1);
    sa_full = 2'b11;

    // R arbitration: two 4-beat bursts
    RREADY_M = 1'b1; ncap = 0;
    rem[0] = 4; rem[1] = 4; beat[0] = 0; beat[1] = 0;
    drive_slaves();
    tick();
    chk("arb_grant0", 64'(rgrant), 64'd0);
    chk("arb_locked", 64'(mrd_full), 64'd0);
    for (int i = 0; i < 13; i++) tick();
    chk("arb_ncap", 64'(ncap), 64'd8);
    chk("arb_b0", 64'(cap_data[0]), 64'hA000_0000);
    chk("arb_b3", 64'(cap_data[3]), 64'hA000_0003);
    chk("arb_last3", 64'(cap_last[3]), 64'd1);
    chk("arb_b4", 64'(cap_data[4]), 64'hA000_0100);
    chk("arb_b7", 64'(cap_data[7]), 64'hA000_0103);
    chk("arb_last7", 64'(cap_last[7]), 64'd1);
    chk("arb_last2", 64'(cap_last[2]), 64'd0);
    chk("arb_grant_held", 64'(rgrant), 64'd1);
    chk("arb_idle_full", 64'(mrd_full), 64'd1);

    // Round-robin pointer back at 0: both request, slave 0 wins
    ncap = 0;
    rem[0] = 1; rem[1] = 1; beat[0] = 0; beat[1] = 0;
    drive_slaves();
    tick();
    chk("rr_grant0", 64'(rgrant), 64'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("rr_ncap", 64'(ncap), 64'd2);
    chk("rr_first", 64'(cap_data[0]), 64'hA000_0000);
    chk("rr_second", 64'(cap_data[1]), 64'hA000_0100);

    // Foreign beats are ignored
    ncap = 0;
    dm[0] = 1'b1; rem[0] = 2; beat[0] = 0;
    drive_slaves();
    for (int i = 0; i < 3; i++) tick();
    chk("foreign_full", 64'(mrd_full), 64'd1);
    chk("foreign_rvalid", 64'(RVALID_M), 64'd0);
    chk("foreign_rem", 64'(rem[0]), 64'd2);
    dm[0] = 1'b0; rem[0] = 0;
    drive_slaves();

    // R FIFO full: 9-beat burst with RREADY_M low
    ncap = 0; RREADY_M = 1'b0;
    rem[1] = 9; beat[1] = 0;
    drive_slaves();
    for (int i = 0; i < 12; i++) tick();
    chk("rfull_rem", 64'(rem[1]), 64'd1);
    chk("rfull_full", 64'(mrd_full), 64'd1);
    chk("rfull_rvalid", 64'(RVALID_M), 64'd1);
    RREADY_M = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    chk("rfull_ncap", 64'(ncap), 64'd9);
    chk("rfull_first", 64'(cap_data[0]), 64'hA000_0100);
    chk("rfull_ninth", 64'(cap_data[8]), 64'hA000_0108);
    chk("rfull_last8", 64'(cap_last[8]), 64'd1);
    chk("rfull_last7", 64'(cap_last[7]), 64'd0);

    // Asynchronous reset mid-burst
    RREADY_M = 1'b0;
    ARVALID_M = 1'b1; ARID_M = 4'd2; ARADDR_M = 32'h0;
    tick();
    ARVALID_M = 1'b0;
    rem[0] = 4; beat[0] = 0;
    drive_slaves();
    for (int i = 0; i < 4; i++) tick();
    chk("ar_pending", 64'(mar_empty), 64'd0);
    chk("burst_rvalid", 64'(RVALID_M), 64'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("arst_rvalid", 64'(RVALID_M), 64'd0);
    chk("arst_ar_empty", 64'(mar_empty), 64'd1);
    chk("arst_arready", 64'(ARREADY_M), 64'd0);
    chk("arst_r_full", 64'(mrd_full), 64'd1);
    rem[0] = 0;
    drive_slaves();
    tick();
    ARESETn = 1'b1;
    tick();
    chk("post_arst_arready", 64'(ARREADY_M), 64'd1);
    chk("post_arst_gv", 64'(mrd_full), 64'd1);
    chk("post_arst_rvalid", 64'(RVALID_M), 64'd0);
    chk("post_arst_ar_empty", 64'(mar_empty), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
